// File: rtl/chip8_tone_mixer.sv
// chip8_tone_mixer: multi-channel square-wave tone generator with attack/release envelopes, mixed per codec request
// Ports:
//   clk, reset (async, active-low)
//   sample_req   codec pulse requesting the next sample
//   tick_60hz    60 Hz pulse decrementing per-channel duration timers
//   cfg_we/cfg_ch/cfg_addr/cfg_wdata  config writes (0=inc, 1=vol, 2=dur, 3=ignored)
//   audio_output signed mix, held between requests; sample_valid pulses when it updates
//   ch_active/any_active  per-channel and global activity (mute = !any_active)
module chip8_tone_mixer #(
  parameter int NUM_CH   = 2,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 4,
  parameter int ENV_W    = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sample_req,
  input  logic                                         tick_60hz,
  input  logic                                         cfg_we,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                   cfg_addr,
  input  logic [PHASE_W-1:0]                           cfg_wdata,
  output logic signed [SAMPLE_W-1:0]                   audio_output,
  output logic                                         sample_valid,
  output logic [NUM_CH-1:0]                            ch_active,
  output logic                                         any_active
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SHIFT = SAMPLE_W - 1 - VOL_W - ENV_W - $clog2(NUM_CH);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
  logic signed [SAMPLE_W-1:0] amp [NUM_CH];
  logic [NUM_CH-1:0] msb, nxt_act;
  logic signed [SAMPLE_W-1:0] mix;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t state, nxt_state;
    logic [PHASE_W-1:0] phase, nxt_phase, inc, nxt_inc;
    logic [VOL_W-1:0] vol, nxt_vol;
    logic [ENV_W-1:0] env, nxt_env;
    logic [7:0] dur, nxt_dur;
    logic [VOL_W+ENV_W-1:0] prod;
    logic sel, wr_dur, dur_nz;
    assign sel = cfg_we && cfg_ch == CH_W'(g);
    assign wr_dur = sel && cfg_addr == 2'd2;
    assign dur_nz = cfg_wdata[7:0] != 8'd0;
    // Envelope steps from the pre-tick state; a dur write or expiry then overrides only the state.
    always_comb begin
      nxt_inc = sel && cfg_addr == 2'd0 ? cfg_wdata : inc;
      nxt_vol = sel && cfg_addr == 2'd1 ? cfg_wdata[VOL_W-1:0] : vol;
      nxt_phase = sample_req && state != IDLE ? phase + inc : phase;
      nxt_state = state;
      nxt_env = env;
      nxt_dur = dur;
      if (sample_req && state == ATTACK) begin
        nxt_state = env >= ENV_MAX - ENV_W'(1) ? SUSTAIN : ATTACK;
        nxt_env = env >= ENV_MAX - ENV_W'(1) ? ENV_MAX : env + ENV_W'(1);
      end
      if (sample_req && state == RELEASE) begin
        nxt_state = env <= ENV_W'(1) ? IDLE : RELEASE;
        nxt_env = env <= ENV_W'(1) ? '0 : env - ENV_W'(1);
      end
      if (wr_dur) begin
        nxt_dur = cfg_wdata[7:0];
        if (dur_nz && (state == IDLE || state == RELEASE)) nxt_state = ATTACK;
        else if (!dur_nz && state != IDLE) nxt_state = RELEASE;
      end else if (tick_60hz && dur != 8'd0) begin
        nxt_dur = dur - 8'd1;
        if (dur == 8'd1 && (state == ATTACK || state == SUSTAIN)) nxt_state = RELEASE;
      end
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        phase <= '0;
        inc <= '0;
        vol <= '0;
        env <= '0;
        dur <= '0;
      end else begin
        state <= nxt_state;
        phase <= nxt_phase;
        inc <= nxt_inc;
        vol <= nxt_vol;
        env <= nxt_env;
        dur <= nxt_dur;
      end
    end
    assign prod = {{ENV_W{1'b0}}, vol} * {{VOL_W{1'b0}}, env};
    assign amp[g] = SAMPLE_W'(prod);
    assign msb[g] = phase[PHASE_W-1];
    assign nxt_act[g] = nxt_state != IDLE;
  end
  // Headroom is reserved by SHIFT, so the sum can never overflow.
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_CH; i++) mix = msb[i] ? mix + amp[i] : mix - amp[i];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      audio_output <= '0;
      sample_valid <= 1'b0;
      ch_active <= '0;
      any_active <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      ch_active <= nxt_act;
      any_active <= |nxt_act;
      if (sample_req) audio_output <= mix <<< SHIFT;
    end
  end
endmodule

// File: tb/tb_chip8_tone_mixer.sv
// tb_chip8_tone_mixer: self-checking bench for chip8_tone_mixer
module tb_chip8_tone_mixer;
  localparam logic [23:0] INC = 24'h400000;
  logic clk, reset, sample_req, tick_60hz, cfg_we;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_addr;
  logic [23:0] cfg_wdata;
  logic signed [15:0] audio_output;
  logic sample_valid, any_active;
  logic [1:0] ch_active;
  int n_vec = 0, n_err = 0;
  int q[$];
  logic last_req;
  logic [23:0] ph0, ph1;
  typedef struct {
    logic req, tick, we;
    logic [1:0] addr;
    logic [23:0] data;
    int exp;
    logic [1:0] act;
  } vec_t;
  vec_t tbl[24];

  chip8_tone_mixer dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .tick_60hz(tick_60hz),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .audio_output(audio_output), .sample_valid(sample_valid),
    .ch_active(ch_active), .any_active(any_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) last_req <= 1'b0;
    else last_req <= sample_req;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every request pushes its expected sample; the output side pops it.
  always @(negedge clk) begin
    if (reset) begin
      if (sample_valid || last_req) chk("valid_cadence", sample_valid, last_req);
      if (sample_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: sample_valid with no expected sample at %0t", $time);
        end else chk("audio", audio_output, q.pop_front());
      end
    end
  end

  function automatic int tone(input logic [23:0] ph, input int env);
    return (ph[23] ? 15 * 64 : -15 * 64) * env;
  endfunction

  function automatic int mn(input int a);
    return a < 15 ? a : 15;
  endfunction

  function automatic vec_t mk(input logic rq, input logic tk, input logic we,
                              input logic [1:0] a, input logic [23:0] d, input int e);
    vec_t v;
    v.req = rq; v.tick = tk; v.we = we; v.addr = a; v.data = d; v.exp = e; v.act = 2'b01;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int addr, input logic [23:0] d);
    cfg_we = 1'b1;
    cfg_ch = ch[0:0];
    cfg_addr = addr[1:0];
    cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic req(input int e);
    sample_req = 1'b1;
    q.push_back(e);
    cyc();
    sample_req = 1'b0;
  endtask

  task automatic tick();
    tick_60hz = 1'b1;
    cyc();
    tick_60hz = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    q.delete();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic setup0(input int d);
    wr(0, 0, INC);
    wr(0, 1, 24'd15);
    wr(0, 2, 24'(d));
    ph0 = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 0, 1, 2'd0, 24'hFFFFFF, 0);
    tbl[1]  = mk(1, 0, 0, 2'd0, 24'h0, -14400);
    tbl[2]  = mk(1, 0, 0, 2'd0, 24'h0, 14400);
    tbl[3]  = mk(1, 0, 0, 2'd0, 24'h0, 14400);
    tbl[4]  = mk(0, 0, 1, 2'd0, INC, 0);
    tbl[5]  = mk(1, 0, 0, 2'd0, 24'h0, 14400);
    tbl[6]  = mk(1, 0, 0, 2'd0, 24'h0, -14400);
    tbl[7]  = mk(0, 0, 1, 2'd2, 24'd0, 0);
    tbl[8]  = mk(1, 0, 0, 2'd0, 24'h0, -14400);
    tbl[9]  = mk(1, 0, 0, 2'd0, 24'h0, 13440);
    tbl[10] = mk(1, 0, 0, 2'd0, 24'h0, 12480);
    tbl[11] = mk(1, 0, 0, 2'd0, 24'h0, -11520);
    tbl[12] = mk(1, 0, 0, 2'd0, 24'h0, -10560);
    tbl[13] = mk(0, 0, 1, 2'd2, 24'd2, 0);
    tbl[14] = mk(1, 0, 0, 2'd0, 24'h0, 9600);
    tbl[15] = mk(1, 0, 0, 2'd0, 24'h0, 10560);
    tbl[16] = mk(1, 0, 0, 2'd0, 24'h0, -11520);
    tbl[17] = mk(1, 0, 0, 2'd0, 24'h0, -12480);
    tbl[18] = mk(1, 0, 0, 2'd0, 24'h0, 13440);
    tbl[19] = mk(1, 0, 0, 2'd0, 24'h0, 14400);
    tbl[20] = mk(0, 1, 0, 2'd0, 24'h0, 0);
    tbl[21] = mk(0, 1, 0, 2'd0, 24'h0, 0);
    tbl[22] = mk(1, 0, 0, 2'd0, 24'h0, -14400);
    tbl[23] = mk(1, 0, 0, 2'd0, 24'h0, -13440);

    clk = 0; reset = 0; sample_req = 0; tick_60hz = 0; cfg_we = 0;
    cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    #2;
    chk("rst_audio", audio_output, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_act", ch_active, 0);
    chk("rst_any", any_active, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    // Single tone: attack ramp into sustain
    setup0(3);
    for (int k = 0; k < 40; k++) begin
      req(tone(ph0, mn(k)));
      ph0 += INC;
      if (k % 3 == 0) cyc();
    end
    chk("tone_act", ch_active, 1);
    chk("tone_any", any_active, 1);
    // Duration expiry then release to idle
    repeat (3) tick();
    chk("expire_act", ch_active, 1);
    for (int j = 0; j < 15; j++) begin
      req(tone(ph0, 15 - j));
      ph0 += INC;
      if (j == 13) chk("rel_act_before", ch_active, 1);
    end
    chk("rel_act_after", ch_active, 0);
    chk("rel_any_after", any_active, 0);
    req(0);

    // Two channels in phase
    reset_dut();
    wr(0, 0, INC); wr(1, 0, INC); wr(0, 1, 24'd15); wr(1, 1, 24'd15);
    wr(0, 2, 24'd50); wr(1, 2, 24'd50);
    ph0 = '0;
    for (int k = 0; k < 20; k++) begin
      req(2 * tone(ph0, mn(k)));
      ph0 += INC;
    end
    chk("mix_act", ch_active, 3);
    // Asynchronous reset while a full-scale sample is presented
    req(2 * tone(ph0, 15));
    chk("pre_rst_audio", audio_output, -28800);
    chk("pre_rst_valid", sample_valid, 1);
    reset = 1'b0;
    q.delete();
    #1;
    chk("async_rst_audio", audio_output, 0);
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_act", ch_active, 0);
    chk("async_rst_any", any_active, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    repeat (3) req(0);
    chk("post_rst_act", ch_active, 0);

    // Two channels half a period apart cancel in sustain
    reset_dut();
    wr(1, 0, INC); wr(1, 1, 24'd15); wr(1, 2, 24'd50);
    ph1 = '0;
    req(tone(ph1, 0)); ph1 += INC;
    req(tone(ph1, 1)); ph1 += INC;
    setup0(50);
    for (int k = 0; k < 20; k++) begin
      req(tone(ph0, mn(k)) + tone(ph1, mn(k + 2)));
      ph0 += INC;
      ph1 += INC;
    end

    // Simultaneous tick and dur write: the write wins
    reset_dut();
    setup0(1);
    for (int k = 0; k < 16; k++) begin
      req(tone(ph0, mn(k)));
      ph0 += INC;
    end
    tick_60hz = 1'b1; cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 2'd2; cfg_wdata = 24'd5;
    cyc();
    tick_60hz = 1'b0; cfg_we = 1'b0;
    chk("wr_tick_act", ch_active, 1);
    repeat (3) begin req(tone(ph0, 15)); ph0 += INC; end
    repeat (4) tick();
    req(tone(ph0, 15)); ph0 += INC;
    chk("dur5_act", ch_active, 1);
    tick();
    req(tone(ph0, 15)); ph0 += INC;
    req(tone(ph0, 14)); ph0 += INC;

    // Tick and request together during attack: attack step first, release next
    reset_dut();
    setup0(1);
    for (int k = 0; k < 3; k++) begin
      req(tone(ph0, k));
      ph0 += INC;
    end
    sample_req = 1'b1; tick_60hz = 1'b1;
    q.push_back(tone(ph0, 3));
    cyc();
    sample_req = 1'b0; tick_60hz = 1'b0;
    ph0 += INC;
    for (int e = 4; e > 0; e--) begin
      req(tone(ph0, e));
      ph0 += INC;
    end
    chk("tick_req_idle", ch_active, 0);

    // Retrigger, wrap and expiry from a sustained tone at phase 0
    reset_dut();
    setup0(50);
    for (int k = 0; k < 16; k++) begin
      req(tone(ph0, mn(k)));
      ph0 += INC;
    end
    for (int i = 0; i < 24; i++) begin
      sample_req = tbl[i].req;
      tick_60hz = tbl[i].tick;
      cfg_we = tbl[i].we;
      cfg_ch = '0;
      cfg_addr = tbl[i].addr;
      cfg_wdata = tbl[i].data;
      if (tbl[i].req) q.push_back(tbl[i].exp);
      cyc();
      sample_req = 1'b0; tick_60hz = 1'b0; cfg_we = 1'b0;
      chk("tbl_act", ch_active, tbl[i].act);
    end

    cyc();
    cyc();
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
